// File: rtl/img_mem_arbiter.sv
// Image BRAM arbiter: host/engine req-gnt sharing with a starvation guard,
// per-port read-return tagging and contention statistics.
module img_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [7:0]        eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [7:0]        eng_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  force_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_HOST,
    TAG_ENG
  } tag_e;

  localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

  tag_e       rd_tag;
  tag_e       tag_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic [7:0] host_hold;
  logic [7:0] eng_hold;
  logic       both;
  logic       force_eng;

  always_comb begin
    both      = host_req & eng_req;
    force_eng = 1'b0;
    host_gnt  = 1'b0;
    eng_gnt   = 1'b0;
    if (!rst) begin
      force_eng = both && (wait_cnt == MAX_W4);
      if (force_eng) begin
        eng_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end else if (eng_req) begin
        eng_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      host_gnt: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_we ? host_wdata : 8'h00;
      end
      eng_gnt: begin
        mem_we    = eng_we;
        mem_addr  = eng_addr;
        mem_wdata = eng_we ? eng_wdata : 8'h00;
      end
      default: ;
    endcase
  end

  // Tag each granted read so the next-cycle BRAM data finds its owner
  always_comb begin
    tag_nxt = TAG_NONE;
    if (host_gnt && !host_we) begin
      tag_nxt = TAG_HOST;
    end else if (eng_gnt && !eng_we) begin
      tag_nxt = TAG_ENG;
    end
  end

  always_comb begin
    wait_nxt = 4'd0;
    if (eng_req && !eng_gnt) begin
      wait_nxt = (wait_cnt >= MAX_W4) ? MAX_W4 : wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag   <= TAG_NONE;
      wait_cnt <= 4'd0;
    end else begin
      rd_tag   <= tag_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_hold <= 8'h00;
      eng_hold  <= 8'h00;
    end else begin
      if (rd_tag == TAG_HOST) host_hold <= mem_rdata;
      if (rd_tag == TAG_ENG)  eng_hold  <= mem_rdata;
    end
  end

  assign host_rvalid = (rd_tag == TAG_HOST);
  assign eng_rvalid  = (rd_tag == TAG_ENG);
  assign host_rdata  = host_rvalid ? mem_rdata : host_hold;
  assign eng_rdata   = eng_rvalid ? mem_rdata : eng_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else if (clear_stats) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (both)      conflict_cnt <= conflict_cnt + CNT_W'(1);
      if (force_eng) force_cnt    <= force_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Self-checking bench for img_mem_arbiter: directed table, corner
// sequences and random traffic against a transaction-level model.
module tb_img_mem_arbiter;

  localparam int ADDR_W   = 18;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;

  logic              clk;
  logic              rst;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [7:0]        host_rdata;
  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [7:0]        eng_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              clear_stats;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [CNT_W-1:0]  force_cnt;

  img_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .eng_req     (eng_req),
    .eng_we      (eng_we),
    .eng_addr    (eng_addr),
    .eng_wdata   (eng_wdata),
    .eng_gnt     (eng_gnt),
    .eng_rvalid  (eng_rvalid),
    .eng_rdata   (eng_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .clear_stats (clear_stats),
    .conflict_cnt(conflict_cnt),
    .force_cnt   (force_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port BRAM
  logic [7:0] bram [256];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[7:0]];
  end

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  shadow [256];
  int          m_streak;
  int          m_pend;
  logic [7:0]  m_pval;
  logic [7:0]  m_hh;
  logic [7:0]  m_eh;
  logic [31:0] m_conf;
  logic [31:0] m_frc;

  task automatic model_reset();
    m_streak = 0;
    m_pend   = 0;
    m_pval   = 8'h00;
    m_hh     = 8'h00;
    m_eh     = 8'h00;
    m_conf   = 0;
    m_frc    = 0;
  endtask

  task automatic check_model();
    bit          both;
    bit          frc_now;
    bit          hg;
    bit          eg;
    logic [17:0] ea;
    bit          ewe;
    logic [7:0]  ewd;
    both    = host_req && eng_req;
    frc_now = both && (m_streak == MAX_WAIT);
    eg      = eng_req && (!host_req || frc_now);
    hg      = host_req && !eg;
    ea      = '0;
    ewe     = 0;
    ewd     = 8'h00;
    if (hg) begin
      ea  = host_addr;
      ewe = host_we;
      ewd = host_we ? host_wdata : 8'h00;
    end else if (eg) begin
      ea  = eng_addr;
      ewe = eng_we;
      ewd = eng_we ? eng_wdata : 8'h00;
    end
    chk("m_host_gnt", host_gnt, hg);
    chk("m_eng_gnt", eng_gnt, eg);
    chk("m_mem_we", mem_we, ewe);
    chk("m_mem_addr", mem_addr, ea);
    chk("m_mem_wdata", mem_wdata, ewd);
    chk("m_host_rvalid", host_rvalid, m_pend == 1);
    chk("m_eng_rvalid", eng_rvalid, m_pend == 2);
    chk("m_host_rdata", host_rdata, (m_pend == 1) ? m_pval : m_hh);
    chk("m_eng_rdata", eng_rdata, (m_pend == 2) ? m_pval : m_eh);
    chk("m_conflict_cnt", conflict_cnt, m_conf);
    chk("m_force_cnt", force_cnt, m_frc);
    if (m_pend == 1) m_hh = m_pval;
    if (m_pend == 2) m_eh = m_pval;
    m_pend = 0;
    if (hg || eg) begin
      if (ewe) begin
        shadow[ea[7:0]] = ewd;
      end else begin
        m_pend = hg ? 1 : 2;
        m_pval = shadow[ea[7:0]];
      end
    end
    if (eng_req && !eg) m_streak = (m_streak < MAX_WAIT) ? m_streak + 1 : MAX_WAIT;
    else m_streak = 0;
    if (clear_stats) begin
      m_conf = 0;
      m_frc  = 0;
    end else begin
      m_conf = m_conf + 32'(both);
      m_frc  = m_frc + 32'(frc_now);
    end
  endtask

  task automatic drive(input int hr, input int hw, input int ha, input int hd,
                       input int er, input int ew, input int ea, input int ed,
                       input int clr);
    host_req    = hr[0];
    host_we     = hw[0];
    host_addr   = ADDR_W'(ha);
    host_wdata  = 8'(hd);
    eng_req     = er[0];
    eng_we      = ew[0];
    eng_addr    = ADDR_W'(ea);
    eng_wdata   = 8'(ed);
    clear_stats = clr[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int hreq, hwe, haddr, hwd;
    int ereq, ewe, eaddr, ewd;
    logic hgnt, egnt, hrv, erv;
    logic [7:0] hrd, erd;
  } vec_t;

  function automatic vec_t v(int hreq, int hwe, int haddr, int hwd,
                             int ereq, int ewe, int eaddr, int ewd,
                             int hgnt, int egnt, int hrv, int hrd,
                             int erv, int erd);
    vec_t r;
    r.hreq = hreq; r.hwe = hwe; r.haddr = haddr; r.hwd = hwd;
    r.ereq = ereq; r.ewe = ewe; r.eaddr = eaddr; r.ewd = ewd;
    r.hgnt = hgnt[0]; r.egnt = egnt[0];
    r.hrv  = hrv[0];  r.erv  = erv[0];
    r.hrd  = 8'(hrd); r.erd  = 8'(erd);
    return r;
  endfunction

  vec_t tbl [12];

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      bram[i]   = 8'h00;
      shadow[i] = 8'h00;
    end
    tbl[0]  = v(1,1,5,'hA7,   0,0,0,0,      1,0,0,'h00,0,'h00);
    tbl[1]  = v(1,0,5,0,      0,0,0,0,      1,0,0,'h00,0,'h00);
    tbl[2]  = v(0,0,0,0,      0,0,0,0,      0,0,1,'hA7,0,'h00);
    tbl[3]  = v(0,0,0,0,      1,1,100,'h3C, 0,1,0,'hA7,0,'h00);
    tbl[4]  = v(1,1,101,'h55, 0,0,0,0,      1,0,0,'hA7,0,'h00);
    tbl[5]  = v(0,0,0,0,      1,0,100,0,    0,1,0,'hA7,0,'h00);
    tbl[6]  = v(1,0,101,0,    0,0,0,0,      1,0,0,'hA7,1,'h3C);
    tbl[7]  = v(0,0,0,0,      0,0,0,0,      0,0,1,'h55,0,'h3C);
    tbl[8]  = v(0,0,0,0,      1,1,7,'h11,   0,1,0,'h55,0,'h3C);
    tbl[9]  = v(0,0,0,0,      1,0,7,0,      0,1,0,'h55,0,'h3C);
    tbl[10] = v(0,0,0,0,      0,0,0,0,      0,0,0,'h55,1,'h11);
    tbl[11] = v(0,0,0,0,      0,0,0,0,      0,0,0,'h55,0,'h11);

    // Reset state, requests held high to prove grants are gated
    rst = 1'b1;
    drive(1,0,3,0, 1,0,4,0, 0);
    #3;
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_eng_gnt", eng_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_eng_rdata", eng_rdata, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0,0,0,0, 0,0,0,0, 0);
    model_reset();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].hreq, tbl[i].hwe, tbl[i].haddr, tbl[i].hwd,
            tbl[i].ereq, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd, 0);
      #4;
      chk($sformatf("t%0d_host_gnt", i), host_gnt, tbl[i].hgnt);
      chk($sformatf("t%0d_eng_gnt", i), eng_gnt, tbl[i].egnt);
      chk($sformatf("t%0d_host_rvalid", i), host_rvalid, tbl[i].hrv);
      chk($sformatf("t%0d_host_rdata", i), host_rdata, tbl[i].hrd);
      chk($sformatf("t%0d_eng_rvalid", i), eng_rvalid, tbl[i].erv);
      chk($sformatf("t%0d_eng_rdata", i), eng_rdata, tbl[i].erd);
      check_model();
      tick();
    end

    // Continuous contention: engine forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      drive(1,0,1,0, 1,0,2,0, 0);
      #4;
      chk($sformatf("c%0d_eng_gnt", i), eng_gnt, (i % 5) == 4);
      chk($sformatf("c%0d_host_gnt", i), host_gnt, (i % 5) != 4);
      check_model();
      tick();
    end
    drive(0,0,0,0, 0,0,0,0, 0);
    #4;
    chk("contend_force_cnt", force_cnt, 2);
    chk("contend_conflict_cnt", conflict_cnt, 10);
    check_model();
    tick();

    // clear_stats wins over a same-cycle increment
    drive(1,0,1,0, 1,0,2,0, 1);
    #4;
    check_model();
    tick();
    drive(1,0,1,0, 1,0,2,0, 0);
    #4;
    chk("clr_conflict_zero", conflict_cnt, 0);
    chk("clr_force_zero", force_cnt, 0);
    check_model();
    tick();
    drive(0,0,0,0, 0,0,0,0, 0);
    #4;
    chk("clr_conflict_one", conflict_cnt, 1);
    check_model();
    tick();

    // Reset while a host read is outstanding
    drive(1,0,5,0, 0,0,0,0, 0);
    #4;
    check_model();
    tick();
    drive(1,0,5,0, 1,0,6,0, 0);
    #1;
    rst = 1'b1;
    #2;
    chk("mid_rst_host_rvalid", host_rvalid, 0);
    chk("mid_rst_host_gnt", host_gnt, 0);
    chk("mid_rst_eng_gnt", eng_gnt, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_host_rdata", host_rdata, 0);
    chk("mid_rst_conflict", conflict_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0,0,0,0, 0,0,0,0, 0);
    model_reset();
    #4;
    chk("post_rst_host_rvalid", host_rvalid, 0);
    check_model();
    tick();

    // Random traffic, including dropped requests and stray clears
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 255),
            ($urandom_range(0, 31) == 0) ? 1 : 0);
      #4;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_mem_arbiter.md
Name: img_mem_arbiter

Overview:
- Shares the single-port image BRAM between two requesters: the host port (JTAG register bank: image upload and readback) and the engine port (downscale FSM pixel reads and writes).
- Enforces a req/gnt handshake and fixed priority with a starvation guard.
- Tags each read so the 1-cycle BRAM read data returns only to its owner.
- Counts contention cycles for performance reporting.
- Sits between the JTAG interface, the downscale engine and the image memory.

Parameters:
- ADDR_W, 18, BRAM address width (512*512 pixels).
- MAX_WAIT, 4, consecutive denied engine cycles before the engine is forced a grant; range 1..15.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- host_req  in  1  host access request; held with its signals until host_gnt
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  8  host write pixel
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  8  host read data
- eng_req  in  1  engine access request
- eng_we  in  1  engine write enable
- eng_addr  in  ADDR_W  engine address
- eng_wdata  in  8  engine write pixel
- eng_gnt  out  1  engine access performed this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  8  engine read data
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  8  BRAM write data
- mem_rdata  in  8  BRAM read data, valid 1 cycle after a read address
- clear_stats  in  1  synchronous clear of statistics counters
- conflict_cnt  out  CNT_W  cycles where both ports requested
- force_cnt  out  CNT_W  number of starvation-forced engine grants

Behaviour:
- Reset (async): wait_cnt=0, rd_tag=NONE, held data=0, counters=0.
  - While rst is high, host_gnt=eng_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rdata=0.
- Grant logic is combinational from the current req inputs and registered state. A transfer occurs in the cycle where req&&gnt. At most one gnt per cycle.
- Grant rules:
  - Only one port requesting: that port is granted.
  - Both requesting: host wins unless wait_cnt==MAX_WAIT; in that case the engine wins and force_cnt increments.
  - Neither requesting: no grant, mem_we=0, mem_addr holds 0.
- Memory drive:
  - mem_addr/mem_we/mem_wdata come from the granted port.
  - mem_we = granted_we.
  - mem_wdata = 0 when no write is granted.
- wait_cnt (4 bits):
  - Increments when eng_req && !eng_gnt, saturating at MAX_WAIT.
  - Clears to 0 on eng_gnt, or when eng_req is low.
- Read return:
  - rd_tag is registered each cycle: HOST if host read granted, ENG if engine read granted, else NONE.
  - A granted read in cycle T produces <port>_rvalid=1 in T+1, with <port>_rdata=mem_rdata (combinational pass-through).
  - On that same edge, mem_rdata is captured into the port's hold register. Outside rvalid, <port>_rdata shows the last captured value.
  - Back-to-back reads give one rvalid per cycle, each tagged independently.
- Write/read ordering: a write granted in T followed by a read of the same address in T+1 returns the written data. The BRAM is read-first; the arbiter adds no forwarding.
- conflict_cnt increments in every cycle with host_req&&eng_req. Both counters wrap at 2^CNT_W.
- clear_stats zeroes both counters. It has priority over a same-cycle increment.
- Protocol violation (req dropped before gnt): the port is simply not granted. No error is flagged.
- Reset mid-read: the pending rvalid is lost and is not re-issued after reset.

Test Plan:
- Host only: write addr 5 = 0xA7, then read addr 5 → host_gnt each cycle; host_rvalid one cycle after the read grant with host_rdata=0xA7; eng_rvalid stays 0.
- Both request continuously with MAX_WAIT=4 → host granted 4 cycles, engine granted cycle 5, host next. Pattern repeats; after 10 cycles force_cnt=2 and conflict_cnt=10.
- Engine read addr 100 (0x3C) in T, host read addr 101 (0x55) in T+1 → eng_rvalid/eng_rdata=0x3C at T+1, host_rvalid/host_rdata=0x55 at T+2. No cross-delivery; eng_rdata holds 0x3C afterwards.
- Engine write addr 7 = 0x11 in T, engine read addr 7 in T+1 → eng_rdata=0x11 at T+2.
- Assert rst during an outstanding host read → no host_rvalid after reset; counters 0; all gnt 0 while rst is high.
- clear_stats asserted in a contended cycle → conflict_cnt=0 the next cycle, then increments from 0.
